// File: rtl/mag_sqrt.sv
// mag_sqrt: iterative square root of an unsigned power word (I^2+Q^2).
// Restoring digit-by-digit method, one result bit per clock, valid/ready on both sides.
// Optional feature: define MAG_SQRT_ROUND_EN to round the result to nearest instead of floor.
module mag_sqrt #(
  parameter int unsigned IN_W  = 33,
  parameter int unsigned OUT_W = 17
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  power,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] mag,
  output logic             busy
);

  localparam int unsigned RadW   = 2 * OUT_W;
  localparam int unsigned RemW   = OUT_W + 2;
  // Extra headroom so the trial subtraction's sign bit is never a data bit.
  localparam int unsigned TrialW = OUT_W + 5;
  localparam int unsigned CntW   = $clog2(OUT_W + 1);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e state_q, state_d;

  logic [RadW-1:0]   rad_q;
  logic [RemW-1:0]   rem_q;
  logic [OUT_W-1:0]  root_q;
  logic [CntW-1:0]   cnt_q;
  logic [OUT_W-1:0]  mag_q;

  logic [1:0]        next2;
  logic [TrialW-1:0] shifted;
  logic [TrialW-1:0] sub;
  logic [TrialW-1:0] diff;
  logic              take;
  logic [RemW-1:0]   rem_step;
  logic [OUT_W-1:0]  root_step;
  logic [OUT_W-1:0]  mag_load;
  logic              last;

  // One restoring square-root step on the current remainder/root.
  always_comb begin
    next2     = rad_q[RadW-1 -: 2];
    shifted   = TrialW'({rem_q, next2});
    sub       = TrialW'({root_q, 2'b01});
    diff      = shifted - sub;
    take      = ~diff[TrialW-1];
    // Either branch is bounded by 2*root, so it fits back into RemW bits.
    rem_step  = take ? diff[RemW-1:0] : shifted[RemW-1:0];
    root_step = {root_q[OUT_W-2:0], take};
    last      = (cnt_q == '0);
`ifdef MAG_SQRT_ROUND_EN
    // Round up when the leftover exceeds root; saturate rather than wrap at all-ones.
    if ((rem_step > RemW'(root_step)) && !(&root_step)) begin
      mag_load = root_step + OUT_W'(1);
    end else begin
      mag_load = root_step;
    end
`else
    mag_load = root_step;
`endif
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (in_valid) state_d = StCalc;
      StCalc: if (last) state_d = StDone;
      StDone: if (out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Handshake outputs decoded from state.
  always_comb begin
    in_ready  = 1'b0;
    busy      = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      StIdle:  in_ready  = 1'b1;
      StCalc:  busy      = 1'b1;
      StDone:  out_valid = 1'b1;
      default: in_ready  = 1'b0;
    endcase
  end

  // Datapath: load on accept, iterate in CALC, capture the result on the final step.
  always_ff @(posedge clock) begin
    if (reset) begin
      rad_q  <= '0;
      rem_q  <= '0;
      root_q <= '0;
      cnt_q  <= '0;
      mag_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            rad_q  <= RadW'(power);
            rem_q  <= '0;
            root_q <= '0;
            cnt_q  <= CntW'(OUT_W - 1);
          end
        end
        StCalc: begin
          rad_q  <= {rad_q[RadW-3:0], 2'b00};
          rem_q  <= rem_step;
          root_q <= root_step;
          if (last) begin
            mag_q <= mag_load;
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign mag = mag_q;

endmodule
